// File: rtl/icache_pkg.sv
// ============================================================================
// Module : icache_pkg
// Brief  : Shared FSM state type and address-field geometry for the I-cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    localparam int c_byte_w = 2;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_lsb(input int words);
        return c_byte_w + $clog2(words);
    endfunction

    function automatic int tag_lsb(input int words, input int sets);
        return idx_lsb(words) + $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words, input int sets);
        return addr_w - tag_lsb(words, sets);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    localparam int c_def_addr_w  = 32;
    localparam int c_def_words   = 4;
    localparam int c_def_sets    = 16;
    localparam int c_def_off_w   = off_w(c_def_words);
    localparam int c_def_idx_lsb = idx_lsb(c_def_words);
    localparam int c_def_tag_lsb = tag_lsb(c_def_words, c_def_sets);
    localparam int c_def_tag_w   = tag_w(c_def_addr_w, c_def_words, c_def_sets);

endpackage

`default_nettype wire

// File: rtl/icache_way.sv
// ============================================================================
// Module : icache_way
// Brief  : One way of the I-cache: tag, valid and line storage plus hit compare.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_way #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic [$clog2(SETS)-1:0]  i_lk_idx,
    input  logic [TAG_W-1:0]         i_lk_tag,
    input  logic [$clog2(WORDS)-1:0] i_lk_off,
    output logic                     o_valid,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_rdata,
    input  logic                     i_wr_en,
    input  logic [$clog2(SETS)-1:0]  i_wr_idx,
    input  logic [$clog2(WORDS)-1:0] i_wr_off,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_tag_we,
    input  logic [TAG_W-1:0]         i_wr_tag
);

    logic [DATA_W-1:0] r_data [SETS*WORDS];
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]   r_valid;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_tag_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    // The line only becomes visible once its tag is written on the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    assign o_valid = r_valid[i_lk_idx];
    assign o_hit   = o_valid && (r_tag[i_lk_idx] == i_lk_tag);
    assign o_rdata = r_data[{i_lk_idx, i_lk_off}];

endmodule

`default_nettype wire

// File: rtl/icache_sa_ctrl.sv
// ============================================================================
// Module : icache_sa_ctrl
// Brief  : Set-associative instruction cache controller with burst refill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_sa_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = 32,
    parameter int WORDS  = c_def_words,
    parameter int SETS   = c_def_sets,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] address,
    input  logic              flush,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              cache_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int c_off_w   = off_w(WORDS);
    localparam int c_idx_w   = $clog2(SETS);
    localparam int c_idx_lsb = idx_lsb(WORDS);
    localparam int c_tag_lsb = tag_lsb(WORDS, SETS);
    localparam int c_tag_w   = tag_w(ADDR_W, WORDS, SETS);
    localparam int c_way_w   = (WAYS > 1) ? $clog2(WAYS) : 1;

    if (!is_pow2(WORDS) || WORDS < 2) begin : g_bad_words
        $error("icache_sa_ctrl: WORDS must be a power of two >= 2");
    end
    if (!is_pow2(SETS) || SETS < 2) begin : g_bad_sets
        $error("icache_sa_ctrl: SETS must be a power of two >= 2");
    end
    if (!is_pow2(WAYS)) begin : g_bad_ways
        $error("icache_sa_ctrl: WAYS must be a power of two >= 1");
    end
    if (c_tag_w < 1) begin : g_bad_tag
        $error("icache_sa_ctrl: address too narrow for a tag field");
    end

    state_e                  r_state;
    logic [DATA_W-1:0]       r_instr;
    logic                    r_instr_valid;
    logic                    r_cache_miss;
    logic                    r_mem_req;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [ADDR_W-1:2]       r_addr;
    logic [c_way_w-1:0]      r_victim;
    logic [c_off_w-1:0]      r_cnt;
    logic                    r_flush_pend;
    logic [31:0]             r_hit_cnt;
    logic [31:0]             r_miss_cnt;
    logic [c_way_w-1:0]      r_rr [SETS];

    logic [c_off_w-1:0]      w_off;
    logic [c_idx_w-1:0]      w_idx;
    logic [c_tag_w-1:0]      w_tag;
    logic [WAYS-1:0]         w_hit;
    logic [WAYS-1:0]         w_valid;
    logic [WAYS-1:0]         w_wr_en;
    logic [DATA_W-1:0]       w_rdata [WAYS];
    logic [DATA_W-1:0]       w_hit_data;
    logic [c_way_w-1:0]      w_victim;
    logic                    w_any_hit;
    logic                    w_all_valid;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_flush_now;
    logic                    w_unused;

    assign w_off    = address[c_idx_lsb-1:c_byte_w];
    assign w_idx    = address[c_tag_lsb-1:c_idx_lsb];
    assign w_tag    = address[ADDR_W-1:c_tag_lsb];
    assign w_unused = ^address[c_byte_w-1:0];

    assign w_beat      = (r_state == ST_REFILL) && mem_rvalid;
    assign w_last      = &r_cnt;
    assign w_any_hit   = |w_hit;
    assign w_all_valid = &w_valid;
    // A flush seen during a refill is deferred to the RESPOND->IDLE edge.
    assign w_flush_now = ((r_state == ST_IDLE) && flush) ||
                         ((r_state == ST_RESPOND) && (r_flush_pend || flush));

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_wr_en[g] = w_beat && (r_victim == c_way_w'(g));

        icache_way #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS),
            .SETS   (SETS),
            .TAG_W  (c_tag_w)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .i_flush   (w_flush_now),
            .i_lk_idx  (w_idx),
            .i_lk_tag  (w_tag),
            .i_lk_off  (w_off),
            .o_valid   (w_valid[g]),
            .o_hit     (w_hit[g]),
            .o_rdata   (w_rdata[g]),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_idx  (r_addr[c_tag_lsb-1:c_idx_lsb]),
            .i_wr_off  (r_cnt),
            .i_wr_data (mem_rdata),
            .i_tag_we  (w_wr_en[g] && w_last),
            .i_wr_tag  (r_addr[ADDR_W-1:c_tag_lsb])
        );
    end

    always_comb begin
        w_hit_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_hit[i]) begin
                w_hit_data = w_rdata[i];
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_victim = c_way_w'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_cache_miss  <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_addr        <= '0;
            r_victim      <= '0;
            r_cnt         <= '0;
            r_flush_pend  <= 1'b0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            r_instr_valid <= 1'b0;
            if (w_flush_now) begin
                for (int s = 0; s < SETS; s++) begin
                    r_rr[s] <= '0;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (!flush && cpu_req) begin
                        if (w_any_hit) begin
                            r_instr       <= w_hit_data;
                            r_instr_valid <= 1'b1;
                            r_hit_cnt     <= r_hit_cnt + 32'd1;
                        end else begin
                            r_state      <= ST_REFILL;
                            r_cache_miss <= 1'b1;
                            r_mem_req    <= 1'b1;
                            r_mem_addr   <= {address[ADDR_W-1:c_idx_lsb], {c_idx_lsb{1'b0}}};
                            r_addr       <= address[ADDR_W-1:2];
                            r_victim     <= w_victim;
                            r_cnt        <= '0;
                            r_miss_cnt   <= r_miss_cnt + 32'd1;
                            if (WAYS > 1 && w_all_valid) begin
                                r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
                            end
                        end
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        if (r_cnt == r_addr[c_idx_lsb-1:c_byte_w]) begin
                            r_instr <= mem_rdata;
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state       <= ST_RESPOND;
                            r_instr_valid <= 1'b1;
                            r_cache_miss  <= 1'b0;
                            r_mem_req     <= 1'b0;
                        end
                    end
                end
                ST_RESPOND: begin
                    r_state      <= ST_IDLE;
                    r_flush_pend <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign instruction = r_instr;
    assign instr_valid = r_instr_valid;
    assign cache_miss  = r_cache_miss;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign hit_count   = r_hit_cnt;
    assign miss_count  = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_icache_sa_ctrl.sv
// ============================================================================
// Module : tb_icache_sa_ctrl
// Brief  : Self-checking bench for icache_sa_ctrl with an instruction scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache_sa_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] address = '0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        cache_miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pulse  = 0;
    int          m_hit    = 0;
    int          m_miss   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    icache_sa_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .WORDS  (4),
        .SETS   (16),
        .WAYS   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .address     (address),
        .flush       (flush),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .cache_miss  (cache_miss),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // Backing memory: line 0x100 holds 0xA0..0xA3, every word distinct.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            logic [31:0] exp_w;
            n_pulse++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: instr_valid with instruction=%h, required no pulse", instruction);
            end else begin
                exp_w = sb.pop_front();
                if (instruction !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_instruction: got %h, required %h", instruction, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cpu_req = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        m_hit = 0;
        m_miss = 0;
    endtask

    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int gap, input int flush_after);
        logic [31:0] base;
        int p0;
        base = {a[31:4], 4'h0};
        p0 = n_pulse;
        cpu_req = 1'b1;
        address = a;
        sb.push_back(word_of(a));
        tick();
        cpu_req = 1'b0;
        n_checks++;
        if (exp_hit) begin
            m_hit++;
            if (instr_valid !== 1'b1 || cache_miss !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_%h: instr_valid=%b cache_miss=%b, required 1/0", a, instr_valid, cache_miss);
            end
        end else begin
            m_miss++;
            if (cache_miss !== 1'b1 || mem_req !== 1'b1 || mem_addr !== base) begin
                n_fail++;
                $display("FAIL miss_%h: cache_miss=%b mem_req=%b mem_addr=%h, required 1/1/%h",
                         a, cache_miss, mem_req, mem_addr, base);
            end
            for (int k = 0; k < 4; k++) begin
                mem_rvalid = 1'b1;
                mem_rdata = word_of(base + 32'(4 * k));
                tick();
                mem_rvalid = 1'b0;
                if (k < 3) begin
                    n_checks++;
                    if (mem_req !== 1'b1 || mem_addr !== base || instr_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL refill_hold_%h beat%0d: mem_req=%b mem_addr=%h instr_valid=%b, required 1/%h/0",
                                 a, k, mem_req, mem_addr, instr_valid, base);
                    end
                    if (k == flush_after) begin
                        flush = 1'b1;
                        tick();
                        flush = 1'b0;
                    end
                    for (int g = 0; g < gap; g++) tick();
                end
            end
            n_checks++;
            if (instr_valid !== 1'b1 || cache_miss !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL respond_%h: instr_valid=%b cache_miss=%b mem_req=%b, required 1/0/0",
                         a, instr_valid, cache_miss, mem_req);
            end
        end
        tick();
        n_checks++;
        if (hit_count !== 32'(m_hit) || miss_count !== 32'(m_miss)) begin
            n_fail++;
            $display("FAIL counters_%h: hit=%0d miss=%0d, required %0d/%0d", a, hit_count, miss_count, m_hit, m_miss);
        end
        n_checks++;
        if (n_pulse - p0 != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL pulses_%h: pulses=%0d pending=%0d, required 1/0", a, n_pulse - p0, sb.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (instr_valid !== 1'b0 || cache_miss !== 1'b0 || mem_req !== 1'b0 ||
            hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: iv=%b miss=%b mreq=%b hits=%0d misses=%0d, required all 0",
                     instr_valid, cache_miss, mem_req, hit_count, miss_count);
        end
    endtask

    task automatic test_miss_hit();
        fetch(32'h100, 1'b0, 0, -1);
        fetch(32'h10C, 1'b1, 0, -1);
        fetch(32'h104, 1'b1, 0, -1);
        fetch(32'h1F8, 1'b0, 0, -1);
        fetch(32'h1F4, 1'b1, 0, -1);
    endtask

    task automatic test_eviction();
        apply_reset();
        fetch(32'h100, 1'b0, 0, -1);
        fetch(32'h200, 1'b0, 0, -1);
        fetch(32'h300, 1'b0, 0, -1);
        fetch(32'h208, 1'b1, 0, -1);
        fetch(32'h100, 1'b0, 0, -1);
        fetch(32'h304, 1'b1, 0, -1);
    endtask

    task automatic test_flush_refill();
        apply_reset();
        fetch(32'h100, 1'b0, 0, 1);
        fetch(32'h100, 1'b0, 0, -1);
    endtask

    task automatic test_flush_idle();
        int p0;
        p0 = n_pulse;
        cpu_req = 1'b1; flush = 1'b1; address = 32'h100;
        tick();
        cpu_req = 1'b0; flush = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || cache_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_drop: instr_valid=%b cache_miss=%b, required 0/0", instr_valid, cache_miss);
        end
        tick();
        n_checks++;
        if (hit_count !== 32'(m_hit) || miss_count !== 32'(m_miss) || n_pulse != p0) begin
            n_fail++;
            $display("FAIL flush_idle_count: hit=%0d miss=%0d pulses=%0d, required %0d/%0d/0",
                     hit_count, miss_count, n_pulse - p0, m_hit, m_miss);
        end
        fetch(32'h100, 1'b0, 0, -1);
    endtask

    task automatic test_reset_refill();
        int p0;
        apply_reset();
        p0 = n_pulse;
        cpu_req = 1'b1; address = 32'h100;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata = word_of(32'h100 + 32'(4 * k));
            tick();
        end
        mem_rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || cache_miss !== 1'b0 || miss_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_refill_abort: mem_req=%b cache_miss=%b miss=%0d, required 0/0/0",
                     mem_req, cache_miss, miss_count);
        end
        for (int k = 2; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata = word_of(32'h100 + 32'(4 * k));
            tick();
        end
        mem_rvalid = 1'b0;
        tick();
        n_checks++;
        if (n_pulse != p0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_refill_stray: pulses=%0d mem_req=%b, required 0/0", n_pulse - p0, mem_req);
        end
        fetch(32'h100, 1'b0, 0, -1);
    endtask

    task automatic test_gaps();
        apply_reset();
        fetch(32'h108, 1'b0, 3, -1);
        fetch(32'h10C, 1'b1, 0, -1);
        fetch(32'h100, 1'b1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_eviction();
        test_flush_refill();
        test_flush_idle();
        test_reset_refill();
        test_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
